alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one instance of the team's 16-bit combinational ALU between NUM_REQ requesters.
- Round-robin arbitration with a valid/ready request channel and a valid/ready response channel per requester.
- Registers operands and result, so the ALU sits between two flop stages; one operation in flight at a time.
- Sits between the requesting engines and the ALU datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 16, operand/result width; fixed to the ALU width, not to be overridden.
- CTRL_W, 4, ALU opcode width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester request accept; one-hot or zero.
- req_op1  in  NUM_REQ*DATA_W  flattened operand1; slice i belongs to requester i.
- req_op2  in  NUM_REQ*DATA_W  flattened operand2.
- req_ctrl  in  NUM_REQ*CTRL_W  flattened ALU opcode.
- rsp_valid  out  NUM_REQ  per-requester response valid; one-hot or zero.
- rsp_ready  in  NUM_REQ  per-requester response accept.
- rsp_result  out  DATA_W  shared result bus, meaningful only under rsp_valid.
- rsp_err  out  1  opcode was not 0..5; qualified by rsp_valid.
- busy  out  1  high in EXEC or RESP.

Behaviour:
- Reset: all outputs are 0, FSM goes to IDLE, grant pointer last_grant=NUM_REQ-1 (so requester 0 has highest priority first), and operand/result registers are 0. Reset is async assert and sync deassert (external synchroniser).
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready is combinational: one-hot to the first requester with req_valid set, searching from last_grant+1 modulo NUM_REQ upward.
  - On the edge where any req_valid is high, capture op1/op2/ctrl of the winner, record the owner index, set last_grant to the owner, and go to EXEC.
  - With no requests, stay in IDLE with req_ready=0.
- EXEC:
  - The ALU is driven from the captured registers.
  - On the next edge, capture the ALU result into the result register, set err_q=(ctrl>5), and go to RESP.
  - req_ready is 0.
- RESP:
  - rsp_valid[owner]=1, with rsp_result and rsp_err driven from registers.
  - Hold these stable until rsp_ready[owner]=1 at an edge, then go to IDLE.
  - rsp_ready of non-owners is ignored.
  - req_ready is 0.
- Latency: if a request is accepted at edge E0, rsp_valid is high after E1 (2-cycle latency). The earliest response handshake is at E2, and the earliest next accept is at E3. Peak throughput is one operation per 3 cycles.
- Requester rules: req_valid must not drop and the payload must stay stable until the request is accepted. A requester may hold req_valid high while its own response is pending; it competes again in IDLE.
- ALU semantics are unchanged. Arithmetic is modulo 2^16 (ADD/SUB wrap). A shift by 16 or more yields 0. An illegal opcode yields result 0x0000 with rsp_err=1.
- Fairness: the requester that was just granted is lowest priority next time. With all NUM_REQ requesters continuously requesting, the grant order is strictly cyclic.
- Reset mid-operation: the in-flight operation is dropped with no response, rsp_valid drops immediately on rst_n low, and the pointer returns to its reset value.
- Simultaneous events: a new req_valid arriving during EXEC or RESP is queued only by the requester holding req_valid; there is no buffering inside the block.

Decomposition:
- Package alu_pkg:
  - Opcode constants ALU_ADD=4'h0, ALU_SUB=4'h1, ALU_AND=4'h2, ALU_XOR=4'h3, ALU_SHL=4'h4, ALU_SHR=4'h5, ALU_OP_MAX=4'h5.
  - ALU_DATA_W=16 and ALU_CTRL_W=4.
  - FSM state enum arb_state_t {IDLE, EXEC, RESP}.
- Sub-module rr_picker (parameter N): combinational round-robin one-hot select from a request vector and a pointer. It outputs a grant vector and an index.
- The existing alu is instantiated as u_alu.

Test Plan:
- Single requester: requester 1 sends ADD with 0x0003 and 0x0004. Required: req_ready[1] high in the same cycle, rsp_valid[1] high 2 edges later, rsp_result=0x0007, rsp_err=0.
- All 4 req_valid held high from reset with rsp_ready always 1. Required: grant order 0,1,2,3,0,1, with exactly one request accepted every 3 cycles.
- Wrap and shift cases. Required: SUB 0x0000-0x0001 gives 0xFFFF; ADD 0xFFFF+0x0002 gives 0x0001; SHL 0x0001<<0x0010 gives 0x0000; SHR 0x8000>>0x000F gives 0x0001.
- Backpressure: rsp_ready[2] held low for 5 cycles while requester 0 has req_valid high. Required: rsp_valid[2] and rsp_result stay stable, busy=1, req_ready=0 throughout; requester 0 is accepted 1 cycle after the response handshake.
- Illegal opcode: ctrl=4'hA with operands 0x1234 and 0x5678. Required: rsp_result=0x0000, rsp_err=1.
- Pulse rst_n low while in EXEC. Required: rsp_valid=0 and busy=0 immediately with no response for the dropped operation; after release, simultaneous requests from requesters 0 and 3 grant requester 0 first.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcodes, widths and the arbiter FSM state type.
// Imported by alu, rr_picker users and alu_arbiter.
package alu_pkg;
  localparam int ALU_DATA_W = 16;
  localparam int ALU_CTRL_W = 4;
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD    = 4'h0;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB    = 4'h1;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND    = 4'h2;
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR    = 4'h3;
  localparam logic [ALU_CTRL_W-1:0] ALU_SHL    = 4'h4;
  localparam logic [ALU_CTRL_W-1:0] ALU_SHR    = 4'h5;
  localparam logic [ALU_CTRL_W-1:0] ALU_OP_MAX = 4'h5;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_t;
endpackage

// File: rtl/alu.sv
// alu: 16-bit combinational ALU.
// Ports: op1, op2 operands; ctrl opcode; result (0 for illegal opcodes).
module alu
  import alu_pkg::*;
(
  input  logic [ALU_DATA_W-1:0] op1,
  input  logic [ALU_DATA_W-1:0] op2,
  input  logic [ALU_CTRL_W-1:0] ctrl,
  output logic [ALU_DATA_W-1:0] result
);
  // Any shift amount of 16 or more clears the operand.
  logic big;
  assign big = |op2[ALU_DATA_W-1:4];
  always_comb begin
    result = '0;
    case (ctrl)
      ALU_ADD: result = op1 + op2;
      ALU_SUB: result = op1 - op2;
      ALU_AND: result = op1 & op2;
      ALU_XOR: result = op1 ^ op2;
      ALU_SHL: result = big ? '0 : op1 << op2[3:0];
      ALU_SHR: result = big ? '0 : op1 >> op2[3:0];
      default: result = '0;
    endcase
  end
endmodule

// File: rtl/alu_arbiter_rr_picker.sv
// rr_picker: combinational round-robin one-hot select.
// Ports: req request vector; ptr last granted index; gnt one-hot grant; idx grant index.
module rr_picker #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx
);
  logic [W-1:0] j;
  logic hit;
  // Search starts one past the pointer so the last winner is considered last.
  always_comb begin
    gnt = '0;
    idx = '0;
    hit = 1'b0;
    j = '0;
    for (int k = 1; k <= N; k++) begin
      j = W'((int'(ptr) + k) % N);
      if (!hit && req[j]) begin
        hit = 1'b1;
        gnt[j] = 1'b1;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU between NUM_REQ requesters.
// Ports: clk, rst_n (async active-low); req_valid/req_ready/req_op1/req_op2/req_ctrl
// request channel per requester; rsp_valid/rsp_ready per requester with shared
// rsp_result/rsp_err; busy while an operation is in flight.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = ALU_DATA_W,
  parameter int CTRL_W  = ALU_CTRL_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]  req_op1,
  input  logic [NUM_REQ*DATA_W-1:0]  req_op2,
  input  logic [NUM_REQ*CTRL_W-1:0]  req_ctrl,
  output logic [NUM_REQ-1:0]         rsp_valid,
  input  logic [NUM_REQ-1:0]         rsp_ready,
  output logic [DATA_W-1:0]          rsp_result,
  output logic                       rsp_err,
  output logic                       busy
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  arb_state_t state, next;
  logic [IW-1:0] owner, last, pick;
  logic [NUM_REQ-1:0] gnt;
  logic [DATA_W-1:0] op1_q, op2_q, res_q, alu_res;
  logic [CTRL_W-1:0] ctrl_q;
  logic err_q;
  rr_picker #(.N(NUM_REQ), .W(IW)) u_pick (
    .req (req_valid),
    .ptr (last),
    .gnt (gnt),
    .idx (pick)
  );
  alu u_alu (
    .op1    (op1_q),
    .op2    (op2_q),
    .ctrl   (ctrl_q),
    .result (alu_res)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next;
  end
  always_comb begin
    next = state;
    req_ready = '0;
    rsp_valid = '0;
    case (state)
      IDLE: begin
        req_ready = gnt;
        if (|req_valid) next = EXEC;
      end
      EXEC: next = RESP;
      RESP: begin
        rsp_valid[owner] = 1'b1;
        if (rsp_ready[owner]) next = IDLE;
      end
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op1_q  <= '0;
      op2_q  <= '0;
      ctrl_q <= '0;
      res_q  <= '0;
      err_q  <= 1'b0;
      owner  <= '0;
      last   <= IW'(NUM_REQ - 1);
    end else if (state == IDLE && |req_valid) begin
      op1_q  <= req_op1[pick*DATA_W +: DATA_W];
      op2_q  <= req_op2[pick*DATA_W +: DATA_W];
      ctrl_q <= req_ctrl[pick*CTRL_W +: CTRL_W];
      owner  <= pick;
      last   <= pick;
    end else if (state == EXEC) begin
      res_q <= alu_res;
      err_q <= ctrl_q > ALU_OP_MAX;
    end
  end
  assign busy       = state != IDLE;
  assign rsp_result = res_q;
  assign rsp_err    = err_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed-vector scoreboard bench for alu_arbiter.
module tb_alu_arbiter;
  import alu_pkg::*;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [63:0] req_op1, req_op2;
  logic [15:0] req_ctrl, rsp_result;
  logic rsp_err, busy;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  typedef struct {
    int          idx;
    logic [15:0] res;
    logic        err;
  } exp_t;
  exp_t q[$];
  exp_t e;

  alu_arbiter #(.NUM_REQ(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op1    (req_op1),
    .req_op2    (req_op2),
    .req_ctrl   (req_ctrl),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every response handshake pops one expected entry.
  always @(negedge clk) begin
    if (rst_n && |(rsp_valid & rsp_ready)) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got rsp_valid %b expected none", rsp_valid);
      end else begin
        e = q.pop_front();
        chk("rsp_owner", 32'(rsp_valid), 32'(4'b1 << e.idx));
        chk("rsp_result", 32'(rsp_result), 32'(e.res));
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
      end
    end
  end

  task automatic push(input int i, input logic [15:0] r, input logic er);
    exp_t x;
    x.idx = i;
    x.res = r;
    x.err = er;
    q.push_back(x);
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b, input logic [3:0] c);
    req_op1[i*16 +: 16] = a;
    req_op2[i*16 +: 16] = b;
    req_ctrl[i*4 +: 4] = c;
    req_valid[i] = 1'b1;
  endtask

  task automatic wait_rdy(input int i);
    int n = 0;
    @(negedge clk);
    while (!req_ready[i] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", 32'(req_ready[i]), 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    @(posedge clk);
    while (q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    chk("drain", q.size(), 0);
    #1;
  endtask

  task automatic send(input int i, input logic [15:0] a, input logic [15:0] b,
                      input logic [3:0] c, input logic [15:0] r, input logic er);
    set_req(i, a, b, c);
    wait_rdy(i);
    push(i, r, er);
    @(posedge clk);
    #1 req_valid[i] = 1'b0;
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int prev = 0;
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = '1;
    req_op1 = '0;
    req_op2 = '0;
    req_ctrl = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", 32'(rsp_result), 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    // Single requester 1, ADD 3+4, 2-cycle latency.
    set_req(1, 16'h0003, 16'h0004, ALU_ADD);
    @(negedge clk);
    chk("t1_req_ready", 32'(req_ready), 32'b0010);
    push(1, 16'h0007, 1'b0);
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    @(negedge clk);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_rsp_early", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("t1_rsp_valid", 32'(rsp_valid), 32'b0010);
    drain();
    // Wrap, shift and logic cases.
    send(0, 16'h0000, 16'h0001, ALU_SUB, 16'hFFFF, 1'b0);
    send(3, 16'hFFFF, 16'h0002, ALU_ADD, 16'h0001, 1'b0);
    send(2, 16'h0001, 16'h0010, ALU_SHL, 16'h0000, 1'b0);
    send(1, 16'h8000, 16'h000F, ALU_SHR, 16'h0001, 1'b0);
    send(0, 16'hF0F0, 16'h3C3C, ALU_AND, 16'h3030, 1'b0);
    send(2, 16'hFF00, 16'h0FF0, ALU_XOR, 16'hF0F0, 1'b0);
    send(3, 16'h0003, 16'h0001, ALU_SHL, 16'h0006, 1'b0);
    // Illegal opcode.
    send(1, 16'h1234, 16'h5678, 4'hA, 16'h0000, 1'b1);
    // Backpressure on requester 2 while requester 0 waits.
    rsp_ready = 4'b1011;
    set_req(2, 16'h0010, 16'h0020, ALU_ADD);
    wait_rdy(2);
    push(2, 16'h0030, 1'b0);
    @(posedge clk);
    #1 req_valid[2] = 1'b0;
    set_req(0, 16'h00FF, 16'h0F0F, ALU_XOR);
    @(posedge clk);
    repeat (5) begin
      @(negedge clk);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'b0100);
      chk("bp_result", 32'(rsp_result), 32'h0030);
      chk("bp_busy", 32'(busy), 32'd1);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk);
    #1 rsp_ready = '1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_next_accept", 32'(req_ready), 32'b0001);
    push(0, 16'h0FF0, 1'b0);
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    drain();
    // All four requesting from reset: strictly cyclic, one accept per 3 cycles.
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 16'h0100, 16'(i), ALU_ADD);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      int n = 0;
      @(negedge clk);
      while (req_ready == 0 && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("rr_grant", 32'(req_ready), 32'(4'b1 << (k % 4)));
      if (k > 0) chk("rr_spacing", cyc - prev, 3);
      prev = cyc;
      push(k % 4, 16'h0100 + 16'(k % 4), 1'b0);
      @(posedge clk);
      #1;
    end
    req_valid = '0;
    drain();
    // Reset pulse during EXEC drops the operation and restores the pointer.
    set_req(1, 16'h0005, 16'h0005, ALU_ADD);
    wait_rdy(1);
    push(1, 16'h000A, 1'b0);
    @(posedge clk);
    #1 chk("rst_exec_busy", 32'(busy), 32'd1);
    req_valid[1] = 1'b0;
    void'(q.pop_back());
    rst_n = 1'b0;
    #1;
    chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    set_req(0, 16'h000A, 16'h0001, ALU_ADD);
    set_req(3, 16'h000A, 16'h0001, ALU_SUB);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_grant0", 32'(req_ready), 32'b0001);
    push(0, 16'h000B, 1'b0);
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    wait_rdy(3);
    chk("post_rst_grant3", 32'(req_ready), 32'b1000);
    push(3, 16'h0009, 1'b0);
    @(posedge clk);
    #1 req_valid[3] = 1'b0;
    drain();
    chk("sb_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
